// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, frame
// constants and small helpers used by the loader and its idle timer.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTES_PER_WORD    = 4;
    localparam logic [1:0] LAST_LANE         = 2'd3;

    // Counter must hold limit-1; never narrower than one bit.
    function automatic int timer_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s inside {ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_CHK});
    endfunction

endpackage

// File: rtl/imem_loader_idle_timer.sv
// Idle-gap timer: counts cycles while running without a clear and flags
// expiry once LIMIT-1 idle cycles have been counted.
module imem_loader_idle_timer
    import imem_loader_pkg::*;
#(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    localparam int             W    = timer_width(LIMIT);
    localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    // Saturates at LAST so a lingering run cycle after expiry cannot wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (!i_run || i_clear) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_run && (r_count == LAST);

endmodule

// File: rtl/imem_loader.sv
// Instruction-RAM write side: parses SYNC/count/data/checksum frames from the
// UART byte stream and emits one little-endian 32-bit word write per 4 bytes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W      = 14,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_en,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [15:0]       o_words_loaded
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    state_t            r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [15:0]       r_word_cnt;
    logic [15:0]       r_n;
    logic [7:0]        r_n_lo;
    logic [7:0]        r_chk;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word;

    logic [15:0]       w_count;
    logic              w_count_bad;
    logic [31:0]       w_word_next;
    logic              w_expire;

    assign w_count     = {i_rx_data, r_n_lo};
    assign w_count_bad = (w_count == 16'd0) || (32'(w_count) > MAX_WORDS);

    // Incoming byte lands in lane r_byte_idx; other lanes keep earlier bytes.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign w_word_next[gi*8 +: 8] = (r_byte_idx == 2'(gi)) ? i_rx_data
                                                                   : r_word[gi*8 +: 8];
        end
    endgenerate

    imem_loader_idle_timer #(
        .LIMIT    (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .i_run    (r_busy),
        .i_clear  (i_rx_valid),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
            r_n        <= '0;
            r_n_lo     <= '0;
            r_chk      <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (!i_load_en) begin
                // Abort: words already written stay in RAM, partial word is dropped.
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_byte_idx <= '0;
            end else if (is_busy(r_state) && !i_rx_valid) begin
                if (w_expire) begin
                    r_state <= ST_ERR;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                            r_state    <= ST_CNT_LO;
                            r_busy     <= 1'b1;
                            r_word_cnt <= '0;
                            r_chk      <= '0;
                        end
                    end
                    ST_CNT_LO: begin
                        r_n_lo  <= i_rx_data;
                        r_state <= ST_CNT_HI;
                    end
                    ST_CNT_HI: begin
                        if (w_count_bad) begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_n        <= w_count;
                            r_byte_idx <= '0;
                            r_word_cnt <= '0;
                            r_state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_word     <= w_word_next;
                        r_chk      <= r_chk ^ i_rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == LAST_LANE) begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_word_cnt[ADDR_W-1:0];
                            r_wr_data  <= w_word_next;
                            r_word_cnt <= r_word_cnt + 16'd1;
                            if (r_word_cnt == r_n - 16'd1) begin
                                r_state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        r_busy <= 1'b0;
                        if (i_rx_data == r_chk) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE and ERR hold until load_en drops.
                    end
                endcase
            end
        end
    end

    assign o_wr_en        = r_wr_en;
    assign o_wr_addr      = r_wr_addr;
    assign o_wr_data      = r_wr_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_words_loaded = r_word_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame parsing, packing, checksum, count
// limits, idle timeout, abort and asynchronous reset.
module tb_imem_loader;

    localparam int ADDR_W      = 14;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_en = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    int          wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYC    (TIMEOUT_CYC),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_load_en      (load_en),
        .i_rx_valid     (rx_valid),
        .i_rx_data      (rx_data),
        .o_wr_en        (wr_en),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_words_loaded (words_loaded)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(wr_data);
            $display("[TB] write addr=%0d data=%h", wr_addr, wr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All stimulus tasks start and end on a negedge.
    task automatic drive(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart();
        load_en = 1'b0;
        @(negedge clk);
        load_en = 1'b1;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset();
        load_en = 1'b1;
        idle(2);
        drive(8'hA5);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_wr got en=%b addr=%0d data=%h exp 0/0/0", wr_en, wr_addr, wr_data);
        end
        n_tests++;
        if (done !== 1'b0 || err !== 1'b0 || words_loaded !== 16'd0) begin
            n_fail++; $display("FAIL reset_status got done=%b err=%b wl=%0d exp 0/0/0", done, err, words_loaded);
        end
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_single();
        restart();
        drive(8'hA5);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        drive(8'h01); drive(8'h00);
        drive(8'h13); drive(8'h00); drive(8'h00); drive(8'h00);
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== 14'd0 || wr_data !== 32'h00000013) begin
            n_fail++; $display("FAIL single_write got en=%b addr=%0d data=%h exp 1/0/00000013", wr_en, wr_addr, wr_data);
        end
        drive(8'h13);
        n_tests++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL single_done got done=%b err=%b busy=%b en=%b exp 1/0/0/0", done, err, busy, wr_en);
        end
        idle(2);
        n_tests++;
        if (wa_q.size() != 1 || words_loaded !== 16'd1) begin
            n_fail++; $display("FAIL single_count got writes=%0d wl=%0d exp 1/1", wa_q.size(), words_loaded);
        end
        load_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [16] = '{8'hA5, 8'h03, 8'h00,
                                    8'h44, 8'h33, 8'h22, 8'h11,
                                    8'hEF, 8'hBE, 8'hAD, 8'hDE,
                                    8'h13, 8'h00, 8'h00, 8'h00, 8'h75};
        logic [31:0] exp_w [3]  = '{32'h11223344, 32'hDEADBEEF, 32'h00000013};
        restart();
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        n_tests++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done got done=%b err=%b exp 1/0", done, err);
        end
        idle(2);
        n_tests++;
        if (wa_q.size() != 3 || words_loaded !== 16'd3) begin
            n_fail++; $display("FAIL b2b_count got writes=%0d wl=%0d exp 3/3", wa_q.size(), words_loaded);
        end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            n_tests++;
            if (wa_q[i] != i || wd_q[i] !== exp_w[i]) begin
                n_fail++; $display("FAIL b2b_word%0d got addr=%0d data=%h exp %0d/%h", i, wa_q[i], wd_q[i], i, exp_w[i]);
            end
        end
    endtask

    task automatic test_bad_chk();
        logic [7:0] bytes [15] = '{8'hA5, 8'h03, 8'h00,
                                   8'h13, 8'h00, 8'h00, 8'h00,
                                   8'h01, 8'h01, 8'h01, 8'h01,
                                   8'hFF, 8'hFF, 8'h00, 8'h00};
        restart();
        foreach (bytes[i]) drive(bytes[i]);
        drive(8'h12);
        n_tests++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL badchk_flags got err=%b done=%b exp 1/0", err, done);
        end
        idle(2);
        n_tests++;
        if (wa_q.size() != 3 || words_loaded !== 16'd3) begin
            n_fail++; $display("FAIL badchk_writes got writes=%0d wl=%0d exp 3/3", wa_q.size(), words_loaded);
        end
        if (wd_q.size() == 3) begin
            n_tests++;
            if (wa_q[2] != 2 || wd_q[2] !== 32'h0000FFFF) begin
                n_fail++; $display("FAIL badchk_word2 got addr=%0d data=%h exp 2/0000ffff", wa_q[2], wd_q[2]);
            end
        end
    endtask

    task automatic test_bad_count();
        restart();
        drive(8'hA5); drive(8'h00); drive(8'h00);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cnt0 got err=%b busy=%b exp 1/0", err, busy);
        end
        restart();
        drive(8'hA5); drive(8'h01); drive(8'h40);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cnt16385 got err=%b busy=%b exp 1/0", err, busy);
        end
        idle(2);
        n_tests++;
        if (wa_q.size() != 0 || words_loaded !== 16'd0) begin
            n_fail++; $display("FAIL cnt_writes got writes=%0d wl=%0d exp 0/0", wa_q.size(), words_loaded);
        end
        restart();
        drive(8'hA5); drive(8'h00); drive(8'h40);
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL cnt16384 got err=%b busy=%b exp 0/1", err, busy);
        end
    endtask

    task automatic test_timeout();
        restart();
        drive(8'hA5); drive(8'h01); drive(8'h00); drive(8'h13); drive(8'h00);
        idle(TIMEOUT_CYC - 1);
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL tmo_edge_pre got err=%b busy=%b exp 0/1", err, busy);
        end
        drive(8'h00); drive(8'h00); drive(8'h13);
        n_tests++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL tmo_edge_accept got done=%b err=%b exp 1/0", done, err);
        end
        idle(2);
        n_tests++;
        if (wd_q.size() != 1 || (wd_q.size() == 1 && wd_q[0] !== 32'h00000013)) begin
            n_fail++; $display("FAIL tmo_edge_write got writes=%0d exp 1 word 00000013", wd_q.size());
        end
        restart();
        drive(8'hA5); drive(8'h01); drive(8'h00); drive(8'h13); drive(8'h00);
        idle(TIMEOUT_CYC);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL tmo_expire got err=%b busy=%b exp 1/0", err, busy);
        end
        drive(8'h00); drive(8'h00); drive(8'h13);
        idle(2);
        n_tests++;
        if (wa_q.size() != 0 || done !== 1'b0) begin
            n_fail++; $display("FAIL tmo_after got writes=%0d done=%b exp 0/0", wa_q.size(), done);
        end
    endtask

    task automatic test_abort_and_reset();
        restart();
        drive(8'hA5); drive(8'h02); drive(8'h00);
        drive(8'h11); drive(8'h22); drive(8'h33); drive(8'h44);
        drive(8'h55); drive(8'h66);
        load_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL abort_state got busy=%b en=%b err=%b exp 0/0/0", busy, wr_en, err);
        end
        load_en = 1'b1;
        drive(8'h77); drive(8'h88); drive(8'h99); drive(8'hAA);
        idle(2);
        n_tests++;
        if (wa_q.size() != 1 || words_loaded !== 16'd1 || (wd_q.size() == 1 && wd_q[0] !== 32'h44332211)) begin
            n_fail++; $display("FAIL abort_writes got writes=%0d wl=%0d exp 1 write 44332211, wl 1", wa_q.size(), words_loaded);
        end
        restart();
        drive(8'hA5); drive(8'h02); drive(8'h00);
        drive(8'h01); drive(8'h02); drive(8'h03); drive(8'h04);
        drive(8'h05); drive(8'h06);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || words_loaded !== 16'd0 || wr_data !== 32'h0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL async_rst got busy=%b wl=%0d data=%h en=%b exp 0/0/0/0", busy, words_loaded, wr_data, wr_en);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(8'h07); drive(8'h08);
        idle(2);
        n_tests++;
        if (wa_q.size() != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_nowrite got writes=%0d busy=%b exp 1/0", wa_q.size(), busy);
        end
        drive(8'hA5); drive(8'h01); drive(8'h00);
        drive(8'h78); drive(8'h56); drive(8'h34); drive(8'h12);
        drive(8'h08);
        idle(2);
        n_tests++;
        if (done !== 1'b1 || wa_q.size() != 2 ||
            (wa_q.size() == 2 && (wa_q[1] != 0 || wd_q[1] !== 32'h12345678))) begin
            n_fail++; $display("FAIL reload got done=%b writes=%0d exp done 1, 2nd write addr 0 data 12345678", done, wa_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_chk();
        test_bad_count();
        test_timeout();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
